// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line and tick in, received word and done strobe out.
interface uart_rx_if #(parameter int NB_DATA = 8);
    logic i_bit;
    logic i_tick;
    logic o_done_data;
    logic [NB_DATA-1:0] o_data;
    modport master(output i_bit, i_tick, input o_done_data, o_data);
    modport slave(input i_bit, i_tick, output o_done_data, o_data);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, mid-bit sampling, LSB-first, one-clock done strobe.
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input logic      i_clk,
    input logic      i_rst,
    uart_rx_if.slave bus
);
    localparam int SW = $clog2(SB_TICK) > 4 ? $clog2(SB_TICK) : 4;
    localparam int NW = NB_DATA > 1 ? $clog2(NB_DATA) : 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [NW-1:0] n_q, n_d;
    logic [NB_DATA-1:0] sh_q, sh_d, data_q, data_d;
    logic done_q, done_d;
    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        sh_d    = sh_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:
                if (!bus.i_bit) begin
                    state_d = START;
                    s_d     = '0;
                end
            START:
                if (bus.i_tick) begin
                    if (s_q == SW'(7)) begin
                        // a line that is high again at mid start bit was only a glitch
                        state_d = bus.i_bit ? IDLE : DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else
                        s_d = s_q + SW'(1);
                end
            DATA:
                if (bus.i_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        sh_d    = {bus.i_bit, sh_q[NB_DATA-1:1]};
                        state_d = (n_q == NW'(NB_DATA - 1)) ? STOP : DATA;
                        n_d     = (n_q == NW'(NB_DATA - 1)) ? n_q : n_q + NW'(1);
                    end else
                        s_d = s_q + SW'(1);
                end
            STOP:
                if (bus.i_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        s_d     = '0;
                        data_d  = sh_q;
                        done_d  = 1'b1;
                    end else
                        s_d = s_q + SW'(1);
                end
            default: state_d = IDLE;
        endcase
    end
    assign bus.o_done_data = done_q;
    assign bus.o_data      = data_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random-frame scoreboard bench for a default receiver and a 7-bit / 2-stop receiver.
`timescale 1ns/100ps
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    int   tick_mode = 0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;
    bit   lat_arm = 1'b0;
    int   start_cyc = 0;

    uart_rx_if #(.NB_DATA(8)) bus_a();
    uart_rx_if #(.NB_DATA(7)) bus_b();
    assign bus_a.i_tick = tick;
    assign bus_b.i_tick = tick;

    uart_rx #(.NB_DATA(8), .SB_TICK(16)) u_dut_a (.i_clk(clk), .i_rst(rst_n), .bus(bus_a));
    uart_rx #(.NB_DATA(7), .SB_TICK(32)) u_dut_b (.i_clk(clk), .i_rst(rst_n), .bus(bus_b));

    always #2.5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: tick every other clock (160 ns bit), 1: tick every clock, 2: random ticks
    initial forever begin
        @(negedge clk);
        tick = tick_mode == 1 ? 1'b1 : tick_mode == 0 ? ~tick : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (bus_a.o_done_data) begin
            if (exp_a.size() == 0) chk("unexpected_done_a", 1, 0);
            else begin
                last_a = exp_a.pop_front();
                chk("data_a", bus_a.o_data, last_a);
                if (lat_arm) begin
                    chk("latency_a", cyc - start_cyc, 153);
                    lat_arm = 1'b0;
                end
            end
        end else chk("hold_a", bus_a.o_data, last_a);
        if (bus_b.o_done_data) begin
            if (exp_b.size() == 0) chk("unexpected_done_b", 1, 0);
            else begin
                last_b = exp_b.pop_front();
                chk("data_b", bus_b.o_data, last_b);
            end
        end else chk("hold_b", bus_b.o_data, last_b);
    end

    task automatic set_line(input int d, input logic b);
        if (d == 0) bus_a.i_bit = b;
        else bus_b.i_bit = b;
    endtask

    task automatic wait_ticks(input int k);
        repeat (k) begin
            do @(posedge clk); while (!tick);
        end
    endtask

    task automatic bit_out(input int d, input logic b, input int k);
        @(negedge clk);
        set_line(d, b);
        wait_ticks(k);
    endtask

    task automatic send(input int d, input logic [7:0] v, input bit lat);
        int nb = d == 0 ? 8 : 7;
        int sb = d == 0 ? 16 : 32;
        if (d == 0) exp_a.push_back(v);
        else exp_b.push_back(v & 8'h7f);
        @(negedge clk);
        set_line(d, 1'b0);
        if (lat) begin
            start_cyc = cyc;
            lat_arm = 1'b1;
        end
        wait_ticks(16);
        for (int i = 0; i < nb; i++) bit_out(d, v[i], 16);
        bit_out(d, 1'b1, sb);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        last_a = 8'h00;
        last_b = 8'h00;
        exp_a.delete();
        exp_b.delete();
        lat_arm = 1'b0;
    endtask

    initial begin
        logic [7:0] sweep[4] = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
        bus_a.i_bit = 1'b1;
        bus_b.i_bit = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_data_a", bus_a.o_data, 0);
        chk("rst_done_a", bus_a.o_done_data, 0);
        chk("rst_data_b", bus_b.o_data, 0);
        chk("rst_done_b", bus_b.o_done_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bit_out(0, 1'b1, 20);
        send(0, 8'h06, 0);
        bit_out(0, 1'b1, 10);
        foreach (sweep[i]) begin
            send(0, sweep[i], 0);
            bit_out(0, 1'b1, 5);
        end
        bit_out(0, 1'b0, 4);
        bit_out(0, 1'b1, 24);
        send(0, 8'h3C, 0);
        send(0, 8'hC3, 0);
        bit_out(0, 1'b1, 8);
        tick_mode = 1;
        bit_out(0, 1'b1, 4);
        send(0, 8'($urandom), 1);
        bit_out(0, 1'b1, 8);
        chk("latency_seen", lat_arm, 0);
        tick_mode = 2;
        for (int i = 0; i < 24; i++) begin
            int d = int'($urandom_range(0, 1));
            send(d, 8'($urandom), 0);
            if ($urandom_range(0, 1) == 1) bit_out(d, 1'b1, int'($urandom_range(1, 20)));
        end
        tick_mode = 0;
        bit_out(1, 1'b1, 20);
        send(1, 8'h55, 0);
        send(1, 8'($urandom), 0);
        send(1, 8'($urandom), 0);
        bit_out(1, 1'b1, 10);
        send(0, 8'h99, 0);
        @(negedge clk);
        set_line(0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 3; i++) bit_out(0, 1'($urandom_range(0, 1)), 16);
        wait_ticks(5);
        do_reset();
        @(negedge clk);
        chk("abort_data_a", bus_a.o_data, 0);
        chk("abort_done_a", bus_a.o_done_data, 0);
        set_line(0, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bit_out(0, 1'b1, 200);
        send(0, 8'hE7, 0);
        bit_out(0, 1'b1, 40);
        chk("pending_a", exp_a.size(), 0);
        chk("pending_b", exp_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART serial receiver with oversampled bit timing.
- Detects a start bit on the serial line, samples NB_DATA data bits LSB-first at mid-bit, then waits out the stop period.
- Presents the received byte in parallel with a one-clock done strobe.
- Sits behind a baud-rate generator that supplies a 16x-oversampling tick enable, and ahead of the UART interface/ALU logic.

Parameters:
- NB_DATA, 8, number of data bits per frame.
- SB_TICK, 16, stop-period length in ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- i_clk  in  1  system clock; all state changes on rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_bit  in  1  serial line; idle high.
- i_tick  in  1  oversampling enable from the baud generator, 16 per bit period.
  - Sampled every clock; each clock with i_tick=1 counts as one tick.
- o_done_data  out  1  one-clock pulse when a frame completes.
- o_data  out  NB_DATA  received word; bit 0 is the first data bit received.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - state=IDLE, tick counter s=0, bit counter n=0, shift register=0.
  - o_data=0, o_done_data=0.
- Reset asserted mid-frame aborts the frame immediately, with no done pulse.
- Counters:
  - s is 4 bits minimum, wide enough for SB_TICK-1.
  - n counts 0..NB_DATA-1.
  - Counters advance only in clocks where i_tick=1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - i_bit=0 in any clock (tick not required) -> START with s=0.
  - Otherwise stay in IDLE.
- START, on tick:
  - s==7 (mid start bit): if i_bit=0 -> DATA, s=0, n=0; if i_bit=1 (glitch) -> IDLE, no output.
  - Else s=s+1.
- DATA, on tick:
  - s==15: s=0 and shift right with i_bit entering the MSB (LSB-first reception).
  - Then if n==NB_DATA-1 -> STOP, else n=n+1.
  - Else s=s+1.
- STOP, on tick:
  - s==SB_TICK-1: o_data <= assembled word, o_done_data pulses, -> IDLE.
  - Else s=s+1.
  - The stop bit value is not checked; no framing-error output.
- o_done_data:
  - Registered; high for exactly one clock, in the clock after the edge that consumed the final stop tick.
  - o_data is valid in that same clock.
- o_data holds its value until the next completed frame.
- Back-to-back frames:
  - After the done pulse, IDLE immediately re-arms.
  - A falling edge in the first clock of IDLE starts a new frame.
- i_tick held constantly high: the FSM advances one count per clock, i.e. a legal 16-clock bit period.
- Line low while in IDLE after reset: treated as a start bit; the START mid-check filters it if the line returns high before s==7.
- Latency, start edge to done:
  - about 8 + 16*NB_DATA + SB_TICK ticks, plus 1 clock.
  - With the defaults: 152 ticks after the falling edge.

Test Plan:
- Reset behaviour:
  - Hold i_rst=0 with i_bit=1 -> o_data=0x00, o_done_data=0.
  - Assert i_rst=0 mid-DATA -> outputs stay or return to 0 and no done pulse follows.
- Basic frame (clk period 5 ns; i_tick = 1 clock high every 10 ns; bit time 160 ns):
  - Release reset at 10 ns; drive start=0 at 170 ns.
  - Data bits 0,1,1,0,0,0,0,0 in 160 ns steps; stop=1.
  - -> single o_done_data pulse about 1.5 µs after the start edge; o_data=0x06.
- Pattern sweep:
  - Frames carrying 0x00, 0xFF, 0xA5 and 0x5A -> o_data equals each value exactly.
  - Exactly one done pulse per frame.
- Start glitch:
  - Pulse i_bit low for 4 ticks, then high -> FSM returns to IDLE, no done, o_data unchanged.
- Back-to-back:
  - Two frames 0x3C then 0xC3 with no idle gap after the stop bit -> two done pulses, o_data=0x3C then 0xC3.
- Parameters:
  - NB_DATA=7, SB_TICK=32, frame 0x55 -> o_data=7'h55, done after a 2-bit stop period.
